fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 68 ++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding the IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] VALID = 3'd3;
    localparam logic [2:0] DROP  = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;

    assign imem_req  = state == REQ;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            fetch_valid     <= 1'b0;
        end else if (redirect) begin
            pc              <= {redirect_pc[31:2], 2'b00};
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            fetch_valid     <= 1'b0;
            // a request still in flight must have its response swallowed before refetching
            state <= (state == WAIT || state == DROP) ? (imem_rvalid ? REQ : DROP) :
                     (state == REQ && imem_ready) ? DROP : REQ;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: if (imem_ready) state <= WAIT;
                WAIT: if (imem_rvalid) begin
                    pc_out          <= pc;
                    instruction_out <= imem_rdata;
                    fetch_valid     <= 1'b1;
                    state           <= VALID;
                end
                VALID: if (pc_write) begin
                    pc              <= pc + 32'd4;
                    instruction_out <= NOP_INSTR;
                    fetch_valid     <= 1'b0;
                    state           <= REQ;
                end
                DROP: if (imem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
